// File: rtl/alu_mc.sv
// alu_mc: multicycle EX-stage ALU with a valid/ready handshake.
// Saturating signed ADD/SUB, per-lane saturating packed add, AND/NOR,
// iterative 1-bit-per-cycle shifts, LLB/LHB. Result and flags are registered
// together and held stable in DONE until the consumer takes them.
module alu_mc #(
    parameter int WIDTH   = 16,
    parameter int LANE_W  = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         func,
    input  logic [WIDTH-1:0]   src0,
    input  logic [WIDTH-1:0]   src1,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   dst,
    output logic               ov,
    output logic               zr,
    output logic               neg
);

    localparam int LANES = WIDTH / LANE_W;
    localparam int MSB   = WIDTH - 1;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_PADDSB = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_AND    = 4'b0011;
    localparam logic [3:0] OP_NOR    = 4'b0100;
    localparam logic [3:0] OP_SLL    = 4'b0101;
    localparam logic [3:0] OP_SRL    = 4'b0110;
    localparam logic [3:0] OP_SRA    = 4'b0111;
    localparam logic [3:0] OP_LLB    = 4'b1000;
    localparam logic [3:0] OP_LHB    = 4'b1001;

    localparam logic [WIDTH-1:0]  SAT_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]  SAT_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [LANE_W-1:0] LSAT_POS = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] LSAT_NEG = {1'b1, {(LANE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [3:0]         func_r;
    logic [WIDTH-1:0]   work_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [WIDTH-1:0]   dst_r;
    logic               ov_r;
    logic               zr_r;
    logic               neg_r;

    logic [WIDTH-1:0]   add_sum_s;
    logic [WIDTH-1:0]   sub_diff_s;
    logic               add_ov_s;
    logic               sub_ov_s;
    logic [WIDTH-1:0]   padd_res_s;
    logic               padd_ov_s;
    logic [LANE_W-1:0]  lane_sum_s;
    logic [WIDTH-1:0]   res_s;
    logic               res_ov_s;
    logic               res_neg_s;
    logic               is_shift_s;
    logic               start_shift_s;
    logic [WIDTH-1:0]   shift_s;

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign dst       = dst_r;
    assign ov        = ov_r;
    assign zr        = zr_r;
    assign neg       = neg_r;

    assign add_sum_s  = src0 + src1;
    assign sub_diff_s = src0 - src1;
    // Overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips.
    assign add_ov_s   = (src0[MSB] == src1[MSB]) && (add_sum_s[MSB] != src0[MSB]);
    assign sub_ov_s   = (src0[MSB] != src1[MSB]) && (sub_diff_s[MSB] != src0[MSB]);

    assign is_shift_s    = (func == OP_SLL) || (func == OP_SRL) || (func == OP_SRA);
    assign start_shift_s = is_shift_s && (shamt != '0);

    // Packed add: each lane saturates on its own, no carry crosses a lane boundary.
    always_comb begin
        padd_res_s = '0;
        padd_ov_s  = 1'b0;
        lane_sum_s = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum_s = src0[i*LANE_W +: LANE_W] + src1[i*LANE_W +: LANE_W];
            if ((src0[i*LANE_W + LANE_W - 1] == src1[i*LANE_W + LANE_W - 1]) &&
                (lane_sum_s[LANE_W-1] != src0[i*LANE_W + LANE_W - 1])) begin
                padd_ov_s = 1'b1;
                padd_res_s[i*LANE_W +: LANE_W] =
                    src0[i*LANE_W + LANE_W - 1] ? LSAT_NEG : LSAT_POS;
            end else begin
                padd_res_s[i*LANE_W +: LANE_W] = lane_sum_s;
            end
        end
    end

    // Single-cycle result mux; shift opcodes pass src0 through (used when shamt==0).
    always_comb begin
        res_s     = '0;
        res_ov_s  = 1'b0;
        res_neg_s = 1'b0;
        case (func)
            OP_ADD: begin
                res_s     = add_ov_s ? (src0[MSB] ? SAT_NEG : SAT_POS) : add_sum_s;
                res_ov_s  = add_ov_s;
                res_neg_s = res_s[MSB];
            end
            OP_PADDSB: begin
                res_s    = padd_res_s;
                res_ov_s = padd_ov_s;
            end
            OP_SUB: begin
                res_s     = sub_ov_s ? (src0[MSB] ? SAT_NEG : SAT_POS) : sub_diff_s;
                res_ov_s  = sub_ov_s;
                res_neg_s = res_s[MSB];
            end
            OP_AND:  res_s = src0 & src1;
            OP_NOR:  res_s = ~(src0 | src1);
            OP_SLL:  res_s = src0;
            OP_SRL:  res_s = src0;
            OP_SRA:  res_s = src0;
            OP_LLB:  res_s = {src0[WIDTH-1:8], src1[7:0]};
            OP_LHB:  res_s = {src1[7:0], src0[WIDTH-9:0]};
            default: res_s = '0;
        endcase
    end

    // One-bit step of the iterative shifter, selected by the latched opcode.
    always_comb begin
        shift_s = work_r;
        case (func_r)
            OP_SLL:  shift_s = {work_r[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_s = {1'b0, work_r[WIDTH-1:1]};
            OP_SRA:  shift_s = {work_r[MSB], work_r[WIDTH-1:1]};
            default: shift_s = work_r;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = start_shift_s ? ST_SHIFT : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == SHAMT_W'(1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand latch, shift iteration and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            func_r <= 4'b0000;
            work_r <= '0;
            cnt_r  <= '0;
            dst_r  <= '0;
            ov_r   <= 1'b0;
            zr_r   <= 1'b1;
            neg_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        func_r <= func;
                        if (start_shift_s) begin
                            work_r <= src0;
                            cnt_r  <= shamt;
                        end else begin
                            dst_r <= res_s;
                            ov_r  <= res_ov_s;
                            zr_r  <= (res_s == '0);
                            neg_r <= res_neg_s;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_r <= shift_s;
                    cnt_r  <= cnt_r - SHAMT_W'(1);
                    if (cnt_r == SHAMT_W'(1)) begin
                        dst_r <= shift_s;
                        ov_r  <= 1'b0;
                        zr_r  <= (shift_s == '0);
                        neg_r <= 1'b0;
                    end
                end
                default: begin
                    // DONE holds the result until the consumer takes it.
                end
            endcase
        end
    end

endmodule
